// File: rtl/switch_allocator.sv
// Switch allocator for a 5-port mesh router: per-output round-robin
// head arbitration with wormhole locking from head to tail.
module switch_allocator #(
  parameter int         NPORTS   = 5,
  parameter logic [2:0] RR_RESET = 3'd4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NPORTS-1:0]     req_valid,
  input  logic [2*NPORTS-1:0]   req_type,
  input  logic [3*NPORTS-1:0]   req_dir,
  input  logic [NPORTS-1:0]     out_ready,
  output logic [NPORTS-1:0]     grant,
  output logic [NPORTS-1:0]     out_valid,
  output logic [3*NPORTS-1:0]   xbar_sel,
  output logic [NPORTS-1:0]     err
);

  localparam logic [1:0] F_HEAD = 2'b11;
  localparam logic [1:0] F_BODY = 2'b01;
  localparam logic [1:0] F_TAIL = 2'b10;
  localparam logic [2:0] NO_SEL = 3'b111;
  localparam logic [2:0] LAST   = 3'(NPORTS - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } lock_t;

  lock_t            lock_q  [NPORTS];
  logic [2:0]       owner_q [NPORTS];
  logic [2:0]       rr_q    [NPORTS];
  logic [NPORTS-1:0] err_q;

  logic [1:0]        ftype [NPORTS];
  logic [2:0]        fdir  [NPORTS];
  logic [NPORTS-1:0] owns;
  logic [NPORTS-1:0] cand  [NPORTS];
  logic [NPORTS-1:0] win_ok;
  logic [2:0]        win   [NPORTS];
  logic [NPORTS-1:0] acquire;
  logic [NPORTS-1:0] release_o;
  logic [NPORTS-1:0] err_set;

  always_comb begin : unpack
    for (int i = 0; i < NPORTS; i++) begin
      ftype[i] = req_type[2*i +: 2];
      fdir[i]  = req_dir[3*i +: 3];
    end
  end

  always_comb begin : owner_map
    owns = '0;
    for (int o = 0; o < NPORTS; o++) begin
      if (lock_q[o] == LOCKED)
        owns[owner_q[o]] = 1'b1;
    end
  end

  // An input already holding an output cannot start a second packet.
  always_comb begin : candidates
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        cand[o][i] = req_valid[i]
                   && (ftype[i] == F_HEAD)
                   && (fdir[i] == 3'(o))
                   && !owns[i];
      end
    end
  end

  always_comb begin : rr_scan
    logic [2:0] idx;
    logic       found;
    logic [2:0] w;
    for (int o = 0; o < NPORTS; o++) begin
      idx   = rr_q[o];
      found = 1'b0;
      w     = NO_SEL;
      for (int k = 0; k < NPORTS; k++) begin
        idx = (idx >= LAST) ? 3'd0 : idx + 3'd1;
        if (!found && cand[o][idx]) begin
          found = 1'b1;
          w     = idx;
        end
      end
      win_ok[o] = found;
      win[o]    = w;
    end
  end

  always_comb begin : alloc
    grant     = '0;
    out_valid = '0;
    xbar_sel  = '1;
    acquire   = '0;
    release_o = '0;
    for (int o = 0; o < NPORTS; o++) begin
      if (lock_q[o] == LOCKED) begin
        xbar_sel[3*o +: 3] = owner_q[o];
        if (req_valid[owner_q[o]] && out_ready[o]) begin
          grant[owner_q[o]] = 1'b1;
          out_valid[o]      = 1'b1;
          release_o[o]      = (ftype[owner_q[o]] == F_TAIL);
        end
      end else if (win_ok[o] && out_ready[o]) begin
        grant[win[o]]      = 1'b1;
        out_valid[o]       = 1'b1;
        xbar_sel[3*o +: 3] = win[o];
        acquire[o]         = 1'b1;
      end
    end
    if (reset) begin
      grant     = '0;
      out_valid = '0;
      xbar_sel  = '1;
      acquire   = '0;
      release_o = '0;
    end
  end

  // Stray body/tail or unroutable head from an input with no lock.
  always_comb begin : err_detect
    for (int i = 0; i < NPORTS; i++) begin
      err_set[i] = req_valid[i] && !owns[i]
                 && (((ftype[i] == F_HEAD) && (fdir[i] > LAST))
                     || (ftype[i] == F_BODY)
                     || (ftype[i] == F_TAIL));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int o = 0; o < NPORTS; o++) begin
        lock_q[o]  <= IDLE;
        owner_q[o] <= 3'd0;
        rr_q[o]    <= RR_RESET;
      end
      err_q <= '0;
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        if (acquire[o]) begin
          lock_q[o]  <= LOCKED;
          owner_q[o] <= win[o];
        end else if (release_o[o]) begin
          lock_q[o] <= IDLE;
          rr_q[o]   <= owner_q[o];
        end
      end
      err_q <= err_q | err_set;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: packets, contention,
// backpressure, lock exclusivity, error flags and async reset.
module tb_switch_allocator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  req_valid;
  logic [9:0]  req_type;
  logic [14:0] req_dir;
  logic [4:0]  out_ready;
  logic [4:0]  grant;
  logic [4:0]  out_valid;
  logic [14:0] xbar_sel;
  logic [4:0]  err;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] H = 2'b11;
  localparam logic [1:0] B = 2'b01;
  localparam logic [1:0] T = 2'b10;

  always #5 clk = ~clk;

  switch_allocator dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_type  (req_type),
    .req_dir   (req_dir),
    .out_ready (out_ready),
    .grant     (grant),
    .out_valid (out_valid),
    .xbar_sel  (xbar_sel),
    .err       (err)
  );

  function automatic logic [14:0] sel1(int o, logic [2:0] v);
    logic [14:0] s;
    s = '1;
    s[3*o +: 3] = v;
    return s;
  endfunction

  task automatic clear_in();
    req_valid = '0;
    req_type  = '0;
    req_dir   = '1;
  endtask

  task automatic put(int i, logic [1:0] t, logic [2:0] d);
    req_valid[i]       = 1'b1;
    req_type[2*i +: 2] = t;
    req_dir[3*i +: 3]  = d;
  endtask

  task automatic drop(int i);
    req_valid[i]       = 1'b0;
    req_type[2*i +: 2] = 2'b00;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [24:0] got;
    clear_in();
    out_ready = '1;
    put(0, H, 3'd2);
    put(3, B, 3'd0);
    #3;
    got = {grant, out_valid, xbar_sel};
    checks++;
    if (got !== {5'b0, 5'b0, 15'h7fff}) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=%h", got, {5'b0, 5'b0, 15'h7fff});
    end
    checks++;
    if (err !== 5'b0) begin
      errors++;
      $display("FAIL reset_err got=%b want=00000", err);
    end
    next_cyc();
    clear_in();
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [1:0]  seq [4];
    logic [24:0] got;
    logic [24:0] exp;
    seq[0] = H; seq[1] = B; seq[2] = B; seq[3] = T;
    out_ready = '1;
    for (int k = 0; k < 4; k++) begin
      clear_in();
      put(4, seq[k], 3'd2);
      @(negedge clk);
      got = {grant, out_valid, xbar_sel};
      exp = {5'b10000, 5'b00100, sel1(2, 3'd4)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_flit%0d got=%h want=%h", k, got, exp);
      end
      next_cyc();
    end
    clear_in();
    @(negedge clk);
    got = {grant, out_valid, xbar_sel};
    checks++;
    if (got !== {5'b0, 5'b0, 15'h7fff}) begin
      errors++;
      $display("FAIL single_idle got=%h want=%h", got, {5'b0, 5'b0, 15'h7fff});
    end
    next_cyc();
  endtask

  task automatic test_contention();
    int          order [3];
    int          w;
    logic [24:0] got;
    logic [24:0] exp;
    order[0] = 0; order[1] = 1; order[2] = 3;
    do_reset();
    out_ready = '1;
    put(0, H, 3'd4);
    put(1, H, 3'd4);
    put(3, H, 3'd4);
    for (int k = 0; k < 6; k++) begin
      w = order[k/2];
      if (k % 2 == 1) put(w, T, 3'd4);
      else if (k > 0) drop(order[k/2 - 1]);
      @(negedge clk);
      got = {grant, out_valid, xbar_sel};
      exp = {5'(1 << w), 5'b10000, sel1(4, 3'(w))};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL contention_c%0d got=%h want=%h", k, got, exp);
      end
      next_cyc();
    end
    clear_in();
    @(negedge clk);
    checks++;
    if (grant !== 5'b0) begin
      errors++;
      $display("FAIL contention_end got=%b want=00000", grant);
    end
    next_cyc();
  endtask

  task automatic test_backpressure();
    logic [1:0]  seq [8];
    logic [4:0]  rdy [8];
    logic        go  [8];
    logic [24:0] got;
    logic [24:0] exp;
    seq[0] = H; seq[1] = B; seq[2] = B; seq[3] = B;
    seq[4] = B; seq[5] = B; seq[6] = T; seq[7] = 2'b00;
    for (int k = 0; k < 8; k++) begin
      rdy[k] = ((k >= 2) && (k <= 4)) ? 5'b11011 : 5'b11111;
      go[k]  = (k < 2) || (k == 5) || (k == 6);
    end
    for (int k = 0; k < 8; k++) begin
      clear_in();
      out_ready = rdy[k];
      if (k < 7) put(4, seq[k], 3'd2);
      @(negedge clk);
      got = {grant, out_valid, xbar_sel};
      if (go[k])
        exp = {5'b10000, 5'b00100, sel1(2, 3'd4)};
      else if (k < 7)
        exp = {5'b0, 5'b0, sel1(2, 3'd4)};
      else
        exp = {5'b0, 5'b0, 15'h7fff};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL backpressure_c%0d got=%h want=%h", k, got, exp);
      end
      next_cyc();
    end
    out_ready = '1;
  endtask

  task automatic test_lock_excl();
    logic [4:0]  eg  [6];
    logic [2:0]  es  [6];
    logic [24:0] got;
    logic [24:0] exp;
    eg[0] = 5'b00001; es[0] = 3'd0;
    eg[1] = 5'b00001; es[1] = 3'd0;
    eg[2] = 5'b00001; es[2] = 3'd0;
    eg[3] = 5'b00100; es[3] = 3'd2;
    eg[4] = 5'b00100; es[4] = 3'd2;
    eg[5] = 5'b00000; es[5] = 3'd7;
    out_ready = '1;
    for (int k = 0; k < 6; k++) begin
      clear_in();
      case (k)
        0: put(0, H, 3'd0);
        1: begin put(0, B, 3'd0); put(2, H, 3'd0); end
        2: begin put(0, T, 3'd0); put(2, H, 3'd0); end
        3: put(2, H, 3'd0);
        4: put(2, T, 3'd0);
        default: ;
      endcase
      @(negedge clk);
      got = {grant, out_valid, xbar_sel};
      exp = {eg[k], (eg[k] != 5'b0) ? 5'b00001 : 5'b0, sel1(0, es[k])};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL lock_excl_c%0d got=%h want=%h", k, got, exp);
      end
      next_cyc();
    end
  endtask

  task automatic test_errors();
    do_reset();
    out_ready = '1;
    put(1, H, 3'b111);
    put(3, B, 3'd0);
    @(negedge clk);
    checks++;
    if ({grant, out_valid, err} !== 15'b0) begin
      errors++;
      $display("FAIL err_first got=%b/%b/%b want=0/0/0", grant, out_valid, err);
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if (err !== 5'b01010 || grant !== 5'b0) begin
      errors++;
      $display("FAIL err_set got err=%b grant=%b want err=01010 grant=00000",
               err, grant);
    end
    next_cyc();
    clear_in();
    put(2, H, 3'd3);
    @(negedge clk);
    checks++;
    if (grant !== 5'b00100 || xbar_sel !== sel1(3, 3'd2)) begin
      errors++;
      $display("FAIL err_other_ok got grant=%b sel=%h want grant=00100 sel=%h",
               grant, xbar_sel, sel1(3, 3'd2));
    end
    next_cyc();
    put(2, T, 3'd3);
    next_cyc();
    clear_in();
    repeat (3) next_cyc();
    @(negedge clk);
    checks++;
    if (err !== 5'b01010) begin
      errors++;
      $display("FAIL err_sticky got=%b want=01010", err);
    end
    next_cyc();
  endtask

  task automatic test_async_reset();
    logic [24:0] got;
    out_ready = '1;
    clear_in();
    put(4, H, 3'd2);
    @(negedge clk);
    checks++;
    if (grant !== 5'b10000) begin
      errors++;
      $display("FAIL areset_pre got=%b want=10000", grant);
    end
    next_cyc();
    put(4, B, 3'd2);
    #2;
    reset = 1'b1;
    #1;
    got = {grant, out_valid, xbar_sel};
    checks++;
    if (got !== {5'b0, 5'b0, 15'h7fff} || err !== 5'b0) begin
      errors++;
      $display("FAIL areset_now got=%h err=%b want=%h err=00000",
               got, err, {5'b0, 5'b0, 15'h7fff});
    end
    next_cyc();
    clear_in();
    put(4, H, 3'd1);
    reset = 1'b0;
    @(negedge clk);
    got = {grant, out_valid, xbar_sel};
    checks++;
    if (got !== {5'b10000, 5'b00010, sel1(1, 3'd4)}) begin
      errors++;
      $display("FAIL areset_after got=%h want=%h",
               got, {5'b10000, 5'b00010, sel1(1, 3'd4)});
    end
    next_cyc();
    put(4, T, 3'd1);
    @(negedge clk);
    checks++;
    if (grant !== 5'b10000 || err !== 5'b0) begin
      errors++;
      $display("FAIL areset_tail got grant=%b err=%b want 10000/00000",
               grant, err);
    end
    next_cyc();
    clear_in();
  endtask

  initial begin
    clear_in();
    out_ready = '1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_lock_excl();
    test_errors();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Per-router switch allocator for the 5-port mesh NoC. It sits between the per-input route computation/input buffers and the 5×5 output crossbar. It arbitrates head flits competing for each output port using per-output round-robin, locks an output to its winning input for the whole packet (head to tail), and issues per-input grants and per-output crossbar selects. Wormhole packet switching; downstream backpressure via `out_ready`.

## Interface
- `NPORTS`, 5, number of ports; only 5 is supported (N=0, S=1, E=2, W=3, L=4)
- `RR_RESET`, 3'd4, reset value of every round-robin pointer, so input 0 has first priority after reset

- `clk`  input  1  clock; all state on rising edge
- `reset`  input  1  asynchronous, active-high; clears all state
- `req_valid`  input  5  input i holds a flit at its buffer head
- `req_type`  input  10  flit type of input i at [2i+1:2i]: 11 head, 01 body, 10 tail (flit bits [1:0])
- `req_dir`  input  15  route of input i at [3i+2:3i] (N/S/E/W/L, 3'b111 invalid); sampled only for head flits
- `out_ready`  input  5  output o can accept a flit this cycle
- `grant`  output  5  input i's flit is forwarded this cycle; input pops on grant
- `out_valid`  output  5  output o carries a flit this cycle
- `xbar_sel`  output  15  source input of output o at [3o+2:3o]; 3'b111 when idle
- `err`  output  5  sticky per-input protocol error flag

## Operation
- Per-output state: `lock[o]` (IDLE/LOCKED), `owner[o]` (3b), `rr_ptr[o]` (3b). Per-input: `err[i]`.
- IDLE output o: candidates are inputs i with `req_valid[i]`, type 11, `req_dir[i]==o`, and i not currently owner of any output. Winner is the first candidate scanning from `rr_ptr[o]+1` mod 5 upward with wrap. If a winner exists and `out_ready[o]`: grant it, drive `xbar_sel[o]`=winner, `out_valid[o]`=1, go LOCKED with `owner[o]`=winner. If `out_ready[o]`=0: no grant and no lock. The winner is recomputed next cycle.
- LOCKED output o: forward owner's flit whenever `req_valid[owner]` and `out_ready[o]`, whatever its type; `req_dir` is ignored. A granted tail (10) returns o to IDLE and sets `rr_ptr[o]`=owner. A head (11) from the owner while locked is forwarded and does not unlock.
- `xbar_sel[o]`=owner whenever LOCKED, even while stalled. `out_valid[o]` only on grant.
- Each input gets at most one grant per cycle; an input owns at most one output.
- Head with `req_dir` of 3'b111, 5 or 6: never granted (input stalls), `err[i]` set.
- Body or tail flit from an input that owns no output: never granted, `err[i]` set.
- `err` is cleared only by reset.

## Timing
- `grant`, `out_valid` and `xbar_sel` are combinational from current inputs and registered state: 0-cycle allocation latency. Lock, owner, rr_ptr and err update at the clock edge after the grant or event.
- Throughput: one flit per output per cycle. A head may be granted the cycle after the previous packet's tail, so there are no bubbles between packets.
- Same-cycle tail release and competing head: the head is not granted that cycle. It competes next cycle under the updated `rr_ptr`.
- Reset: while `reset` is high, `grant`=0, `out_valid`=0, `xbar_sel`=all 3'b111 and `err`=0, regardless of inputs. After reset, all outputs are IDLE with `rr_ptr`=`RR_RESET`. Reset mid-packet drops the lock; flushing the buffers is the upstream's responsibility.

## Test plan
- Single packet, L→E: head dir=2, then 2 body, then tail on input 4, `out_ready`=all 1 → `grant[4]` for 4 consecutive cycles, `xbar_sel[E]`=4, E is IDLE the cycle after the tail.
- Contention: inputs 0, 1 and 3 present heads to output L in the same cycle after reset → order of service 0, 1, 3. Each packet is 2 flits. The L grant has no gaps over 6 cycles.
- Backpressure: `out_ready[E]` low for 3 cycles mid-packet → no grants and `out_valid[E]`=0 for those cycles, `xbar_sel[E]` holds the owner, the packet resumes intact.
- Lock exclusivity: input 2 sends a head to N while input 0 owns N → input 2 is not granted until the cycle after input 0's tail is granted.
- Errors: input 1 head with dir=3'b111, input 3 body flit with no lock → no grants, `err`=5'b01010, which persists until reset.
- Async reset asserted mid-packet → outputs go to their reset values immediately. After release, a new head on the former owner input is arbitrated normally.
